bus_transfer_decoder: RTL and testbench
=======================================

# bus_transfer_decoder

Sequenced bus-select decoder for the processor datapath. It accepts a register-transfer request as a pair of 5-bit select codes, source and destination, in the same numbering the datapath's bus-select encoder produces. It decodes them into one-hot source out-enables and destination in-enables and drives them in a fixed DRIVE→LATCH order. It sits between the control unit and the register file / special registers, so the control unit issues a single transfer command instead of raw enable lines.

## Interface
Parameters:
- `SEL_W`, 5, select-code width.
- `NUM_SRC`, 24, number of decoded sources (codes 0..23).
- `NUM_DST`, 22, number of writable destinations (codes 0..21).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  transfer request present.
- `req_ready`  out  1  block can accept a request.
- `src_sel`  in  SEL_W  source code.
- `dst_sel`  in  SEL_W  destination code.
- `out_en`  out  NUM_SRC  one-hot source bus drive enables.
- `in_en`  out  NUM_DST  one-hot destination latch enables.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky invalid-code flag.
- `err_clr`  in  1  synchronous clear of `err`.

Code map:
- 0–15: R0–R15.
- 16: HI. 17: LO. 18: Zhigh. 19: Zlow. 20: PC. 21: MDR.
- 22: In_Port (source only). 23: C constant (source only).
- 24–31: unused.

## Operation
- FSM states: IDLE, DRIVE, LATCH.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture `src_sel`/`dst_sel` into registers and go to DRIVE.
- DRIVE: `out_en[src]`=1; all `in_en`=0; go to LATCH.
- LATCH:
  - `out_en[src]` stays 1 and `in_en[dst]`=1, so the bus is stable for the whole latch cycle.
  - Go to IDLE.
  - `done` is registered high for the next cycle.
- `req_ready`=0 in DRIVE and LATCH. A request presented there is ignored and must be held by the requester.
- src==dst is legal (register refresh). Both enables for that register are asserted in LATCH.
- Outputs are registered. At most one bit of `out_en` and one bit of `in_en` is ever high.
- Asynchronous `clr_n` low at any time, including mid-transfer:
  - State→IDLE.
  - `out_en`=0, `in_en`=0, `done`=0, `err`=0, captured codes=0.
  - An interrupted transfer is lost and produces no `done`.
- `err_clr` clears `err` on the next edge. If `err_clr` coincides with a new error, set wins.

## Timing
- Request accepted at edge k:
  - `out_en` high from k+1 for 2 cycles.
  - `in_en` high from k+2 for 1 cycle.
  - `done` high for 1 cycle from k+3.
- At k+3 the state is IDLE and `req_ready`=1, so a back-to-back request is accepted on the same edge that ends `done`.
- Peak throughput is one transfer per 3 cycles.
- Reset values: `req_ready`=1 (IDLE), all other outputs 0.

## Configuration
- Macro `BUS_XFER_INVALID_TRAP_EN`.
- Defined:
  - A request with `src_sel`≥24 or `dst_sel`≥22 is still handshaken in IDLE.
  - It does not enter DRIVE. No enables are asserted.
  - The next cycle has `done`=1, `err` is set, and the state remains IDLE.
- Undefined:
  - Invalid codes run the normal DRIVE/LATCH timing.
  - The invalid field decodes to all-zero enables.
  - `err` is tied 0 and `err_clr` is ignored.

## Structure
- Shared package `bus_sel_pkg`:
  - State enum.
  - Code constants SEL_R0..SEL_C.
  - NUM_SRC, NUM_DST.
  - Shared with the bus-select encoder so both ends use one numbering.
- Sub-module `decoder_5_to_32`: combinational one-hot decoder, instantiated twice (source and destination) and truncated to NUM_SRC/NUM_DST.

## Test plan
- Reset, then src=3, dst=7 at edge k:
  - `out_en`=0x000008 at k+1..k+2.
  - `in_en`=0x000080 at k+2 only.
  - `done` at k+3.
- Back-to-back: src=20 (PC), dst=21 (MDR), then src=21, dst=0 presented continuously. The second request is accepted at k+3, `done` pulses at k+3 and k+6, and there are no gaps or overlaps in the enables.
- src=dst=5: bit 5 of both `out_en` and `in_en` is high in the LATCH cycle.
- `clr_n` pulsed low during LATCH (src=16, dst=17): all outputs are 0 asynchronously, no `done` follows, and the next request behaves normally.
- With `BUS_XFER_INVALID_TRAP_EN`, src=23, dst=22:
  - No enables; `done` and `err`=1 one cycle later.
  - `err` holds until `err_clr`.
  - Repeat the test without the macro: DRIVE/LATCH timing runs with `out_en[23]` high, `in_en`=0, and `err`=0 throughout.

Source files
------------

// File: rtl/bus_sel_pkg.sv
// Shared bus-select numbering for the datapath encoder and transfer decoder.
// Holds transfer FSM states, code constants and decoded widths.
package bus_sel_pkg;

  localparam int SEL_W   = 5;
  localparam int NUM_SRC = 24;
  localparam int NUM_DST = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH
  } state_t;

  localparam logic [4:0] SEL_R0      = 5'd0;
  localparam logic [4:0] SEL_R1      = 5'd1;
  localparam logic [4:0] SEL_R2      = 5'd2;
  localparam logic [4:0] SEL_R3      = 5'd3;
  localparam logic [4:0] SEL_R4      = 5'd4;
  localparam logic [4:0] SEL_R5      = 5'd5;
  localparam logic [4:0] SEL_R6      = 5'd6;
  localparam logic [4:0] SEL_R7      = 5'd7;
  localparam logic [4:0] SEL_R8      = 5'd8;
  localparam logic [4:0] SEL_R9      = 5'd9;
  localparam logic [4:0] SEL_R10     = 5'd10;
  localparam logic [4:0] SEL_R11     = 5'd11;
  localparam logic [4:0] SEL_R12     = 5'd12;
  localparam logic [4:0] SEL_R13     = 5'd13;
  localparam logic [4:0] SEL_R14     = 5'd14;
  localparam logic [4:0] SEL_R15     = 5'd15;
  localparam logic [4:0] SEL_HI      = 5'd16;
  localparam logic [4:0] SEL_LO      = 5'd17;
  localparam logic [4:0] SEL_ZHI     = 5'd18;
  localparam logic [4:0] SEL_ZLO     = 5'd19;
  localparam logic [4:0] SEL_PC      = 5'd20;
  localparam logic [4:0] SEL_MDR     = 5'd21;
  localparam logic [4:0] SEL_IN_PORT = 5'd22;
  localparam logic [4:0] SEL_C       = 5'd23;

endpackage

// File: rtl/decoder_5_to_32.sv
// Combinational 5-to-32 one-hot decoder.
// Callers truncate to the number of real enables they need.
module decoder_5_to_32 (
  input  logic [4:0]  sel,
  output logic [31:0] dec
);

  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/bus_transfer_decoder.sv
// Sequenced DRIVE->LATCH bus-select decoder for register transfers.
// Define BUS_XFER_INVALID_TRAP_EN to trap invalid codes into a sticky err.
module bus_transfer_decoder #(
  parameter int SEL_W   = 5,
  parameter int NUM_SRC = 24,
  parameter int NUM_DST = 22
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   src_sel,
  input  logic [SEL_W-1:0]   dst_sel,
  output logic [NUM_SRC-1:0] out_en,
  output logic [NUM_DST-1:0] in_en,
  output logic               done,
  output logic               err,
  input  logic               err_clr
);
  import bus_sel_pkg::*;

  state_t state, state_n;

  logic [SEL_W-1:0]   src_q, src_q_n;
  logic [SEL_W-1:0]   dst_q, dst_q_n;
  logic [SEL_W-1:0]   src_mux, dst_mux;
  logic [31:0]        src_dec, dst_dec;
  logic               src_bad, dst_bad;
  logic               trap;
  logic [NUM_SRC-1:0] src_en, out_n;
  logic [NUM_DST-1:0] dst_en, in_n;
  logic               done_n;
  logic               err_q, err_n;

  // In IDLE decode the live request so out_en can load on accept
  assign src_mux = (state == ST_IDLE) ? src_sel : src_q;
  assign dst_mux = (state == ST_IDLE) ? dst_sel : dst_q;

  decoder_5_to_32 u_src_dec (
    .sel (src_mux),
    .dec (src_dec)
  );

  decoder_5_to_32 u_dst_dec (
    .sel (dst_mux),
    .dec (dst_dec)
  );

  assign src_bad = |src_dec[31:NUM_SRC];
  assign dst_bad = |dst_dec[31:NUM_DST];
  assign src_en  = src_bad ? '0 : src_dec[NUM_SRC-1:0];
  assign dst_en  = dst_bad ? '0 : dst_dec[NUM_DST-1:0];

`ifdef BUS_XFER_INVALID_TRAP_EN
  assign trap = src_bad | dst_bad;
`else
  assign trap = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);
  assign err       = err_q;

  always_comb begin
    state_n = state;
    src_q_n = src_q;
    dst_q_n = dst_q;
    out_n   = '0;
    in_n    = '0;
    done_n  = 1'b0;
    err_n   = err_q & ~err_clr;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (trap) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            state_n = ST_DRIVE;
            src_q_n = src_sel;
            dst_q_n = dst_sel;
            out_n   = src_en;
          end
        end
      end
      ST_DRIVE: begin
        state_n = ST_LATCH;
        out_n   = src_en;
        in_n    = dst_en;
      end
      ST_LATCH: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      out_en <= '0;
      in_en  <= '0;
      done   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      src_q  <= src_q_n;
      dst_q  <= dst_q_n;
      out_en <= out_n;
      in_en  <= in_n;
      done   <= done_n;
      err_q  <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Self-checking bench for bus_transfer_decoder.
// Table-driven transfers feed a per-cycle expectation queue.
module tb_bus_transfer_decoder;
  import bus_sel_pkg::*;

  typedef struct {
    int          cyc;
    logic [23:0] eo;
    logic [21:0] ei;
    logic        done;
    logic        err;
    logic        ready;
  } exp_t;

  typedef struct {
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [23:0] eo;
    logic [21:0] ei;
    bit          bad;
  } vec_t;

`ifdef BUS_XFER_INVALID_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  src_sel = '0;
  logic [4:0]  dst_sel = '0;
  logic [23:0] out_en;
  logic [21:0] in_en;
  logic        done;
  logic        err;
  logic        err_clr = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   quiet_err = 1'b0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  bus_transfer_decoder dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .src_sel   (src_sel),
    .dst_sel   (dst_sel),
    .out_en    (out_en),
    .in_en     (in_en),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1);
  end

  // Cycles without a queued record must be quiet
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_record cycle=%0d got=none required=%0d",
                 cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      e.cyc   = cyc;
      e.eo    = '0;
      e.ei    = '0;
      e.done  = 1'b0;
      e.err   = quiet_err;
      e.ready = 1'b1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc)
        e = exp_q.pop_front();
      checks++;
      if ({out_en, in_en, done, err, req_ready} !==
          {e.eo, e.ei, e.done, e.err, e.ready}) begin
        errors++;
        $display("FAIL cycle_%0d got out=%h in=%h done=%b err=%b rdy=%b required out=%h in=%h done=%b err=%b rdy=%b",
                 cyc, out_en, in_en, done, err, req_ready,
                 e.eo, e.ei, e.done, e.err, e.ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input logic [23:0] eo,
                      input logic [21:0] ei, input logic d,
                      input logic er, input logic rd);
    exp_t e;
    e.cyc   = c;
    e.eo    = eo;
    e.ei    = ei;
    e.done  = d;
    e.err   = er;
    e.ready = rd;
    exp_q.push_back(e);
  endtask

  task automatic push3(input int c, input logic [23:0] eo,
                       input logic [21:0] ei);
    push(c + 1, eo, '0, 1'b0, quiet_err, 1'b0);
    push(c + 2, eo, ei, 1'b0, quiet_err, 1'b0);
    push(c + 3, '0, '0, 1'b1, quiet_err, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic xfer(input vec_t v);
    int c;
    c = cyc;
    src_sel   = v.src;
    dst_sel   = v.dst;
    req_valid = 1'b1;
    if (TRAP && v.bad) begin
      push(c + 1, '0, '0, 1'b1, 1'b1, 1'b1);
      step();
      req_valid = 1'b0;
      quiet_err = 1'b1;
      step();
    end else begin
      push3(c, v.eo, v.ei);
      step();
      req_valid = 1'b0;
      step();
      step();
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr   = 1'b0;
    quiet_err = 1'b0;
    step();
  endtask

  initial begin
    vec_t tbl[9];
    int   c;
    tbl[0] = '{5'd3,  5'd7,  24'h000008, 22'h000080, 1'b0};
    tbl[1] = '{5'd5,  5'd5,  24'h000020, 22'h000020, 1'b0};
    tbl[2] = '{5'd16, 5'd17, 24'h010000, 22'h020000, 1'b0};
    tbl[3] = '{5'd0,  5'd21, 24'h000001, 22'h200000, 1'b0};
    tbl[4] = '{5'd23, 5'd0,  24'h800000, 22'h000001, 1'b0};
    tbl[5] = '{5'd22, 5'd15, 24'h400000, 22'h008000, 1'b0};
    tbl[6] = '{5'd23, 5'd22, 24'h800000, 22'h000000, 1'b1};
    tbl[7] = '{5'd30, 5'd2,  24'h000000, 22'h000004, 1'b1};
    tbl[8] = '{5'd19, 5'd31, 24'h080000, 22'h000000, 1'b1};

    @(posedge clk);
    #1;
    chk("reset_outputs", {15'd0, out_en, in_en, done, err, req_ready},
        64'h1);
    mon_en = 1'b1;
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      xfer(tbl[i]);

    // Back-to-back with the second request held through the first
    c = cyc;
    src_sel   = SEL_PC;
    dst_sel   = SEL_MDR;
    req_valid = 1'b1;
    push3(c, 24'h100000, 22'h200000);
    step();
    src_sel = SEL_MDR;
    dst_sel = SEL_R0;
    push3(c + 3, 24'h200000, 22'h000001);
    step();
    step();
    step();
    req_valid = 1'b0;
    step();
    step();

    clear_err();

`ifdef BUS_XFER_INVALID_TRAP_EN
    c = cyc;
    err_clr   = 1'b1;
    src_sel   = SEL_C;
    dst_sel   = SEL_IN_PORT;
    req_valid = 1'b1;
    push(c + 1, '0, '0, 1'b1, 1'b1, 1'b1);
    step();
    req_valid = 1'b0;
    err_clr   = 1'b0;
    quiet_err = 1'b1;
    step();
    step();
    step();
    clear_err();
`endif

    // Reset pulled during LATCH loses the transfer
    c = cyc;
    src_sel   = SEL_HI;
    dst_sel   = SEL_LO;
    req_valid = 1'b1;
    push(c + 1, 24'h010000, '0, 1'b0, quiet_err, 1'b0);
    push(c + 2, 24'h010000, 22'h020000, 1'b0, quiet_err, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    clr_n     = 1'b0;
    quiet_err = 1'b0;
    #1;
    chk("async_clr", {15'd0, out_en, in_en, done, err, req_ready},
        64'h1);
    step();
    clr_n = 1'b1;
    step();
    xfer(tbl[0]);
    xfer(tbl[1]);

    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
